// File: rtl/divider_if.sv
// ---------------------------------------------------------------------------
// divider_if
//
// Purpose: groups the start/busy/finish handshake, the operands and the
//          results of the sequential divider into one bundle. The bundle has
//          the same shape as the multiplier's, so one controller can drive
//          either unit.
//
// Signals (directions seen from the divider, i.e. the slave side):
//   start_i     in   request a division (sampled only while idle)
//   dividend_i  in   2*WIDTH-bit unsigned dividend
//   divisor_i   in   WIDTH-bit unsigned divisor
//   busy_o      out  operation in progress
//   finish_o    out  one-cycle pulse, results valid
//   div_zero_o  out  last operation had a zero divisor
//   quotient_o  out  2*WIDTH-bit quotient
//   remainder_o out  WIDTH-bit remainder
//
// Modports: master (requester) and slave (divider).
// ---------------------------------------------------------------------------
interface divider_if #(
    parameter int WIDTH = 32
) ();
    logic                 start_i;
    logic [2*WIDTH-1:0]   dividend_i;
    logic [WIDTH-1:0]     divisor_i;
    logic                 busy_o;
    logic                 finish_o;
    logic                 div_zero_o;
    logic [2*WIDTH-1:0]   quotient_o;
    logic [WIDTH-1:0]     remainder_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  busy_o, finish_o, div_zero_o, quotient_o, remainder_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output busy_o, finish_o, div_zero_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
//
// Purpose: sequential unsigned restoring divider, one quotient bit per clock.
//          Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor. A division
//          takes 2*WIDTH RUN cycles, followed by one DONE cycle that pulses
//          finish_o. A zero divisor needs no special datapath: the restoring
//          step then yields an all-ones quotient and a remainder equal to the
//          low WIDTH bits of the dividend. div_zero_o flags that case.
//
// Ports:
//   clk_i   in   rising-edge clock
//   rst_ni  in   asynchronous active-low reset
//   bus     slave modport of divider_if (handshake, operands, results)
//
// Parameters:
//   WIDTH   divisor/remainder width; dividend/quotient are 2*WIDTH
//
// Optional feature macro: DIVIDER_FAST_DIVZERO_EN
//   When defined, a request with a zero divisor goes from IDLE straight to
//   DONE. finish_o then follows one cycle after acceptance and busy_o never
//   rises. When undefined, a zero divisor runs all 2*WIDTH steps and gives
//   the same results.
// ---------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    divider_if.slave  bus
);
    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [DW-1:0]      dvd_q,     dvd_d;      // dividend shift register
    logic [WIDTH-1:0]   dvs_q,     dvs_d;      // captured divisor
    logic [DW-1:0]      quo_q,     quo_d;      // working quotient
    logic [WIDTH-1:0]   rem_q,     rem_d;      // working remainder
    logic [DW-1:0]      res_quo_q, res_quo_d;  // published quotient
    logic [WIDTH-1:0]   res_rem_q, res_rem_d;  // published remainder
    logic               div_zero_q, div_zero_d;

    // One restoring step. The shifted remainder is WIDTH+1 bits wide, so the
    // compare uses the extra bit. After a subtraction the difference is
    // always below the divisor, so the low WIDTH bits hold all of it.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_sub;
    logic               step_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [DW-1:0]      quo_step;

    assign rem_shift = {rem_q, dvd_q[DW-1]};
    assign step_ge   = (rem_shift >= {1'b0, dvs_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    assign rem_step  = step_ge ? rem_sub : rem_shift[WIDTH-1:0];
    assign quo_step  = {quo_q[DW-2:0], step_ge};

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        res_quo_d  = res_quo_q;
        res_rem_d  = res_rem_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    dvd_d   = bus.dividend_i;
                    dvs_d   = bus.divisor_i;
                    quo_d   = '0;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DW - 1);
                    state_d = RUN;
`ifdef DIVIDER_FAST_DIVZERO_EN
                    // Short-cut: publish the known divide-by-zero result now.
                    if (bus.divisor_i == '0) begin
                        res_quo_d  = '1;
                        res_rem_d  = bus.dividend_i[WIDTH-1:0];
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end
`endif
                end
            end

            RUN: begin
                dvd_d = dvd_q << 1;
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q - CNT_W'(1);
                // The step for counter 0 is the last one. Publish its result
                // on the same edge, so the outputs change only when an
                // operation completes.
                if (cnt_q == '0) begin
                    res_quo_d  = quo_step;
                    res_rem_d  = rem_step;
                    div_zero_d = (dvs_q == '0);
                    state_d    = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. All of them clear on reset, so an
    // aborted operation leaves nothing visible behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            res_quo_q  <= '0;
            res_rem_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge, whatever the statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            res_quo_q  <= res_quo_d;
            res_rem_q  <= res_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    // busy_o and finish_o are decoded from distinct states, so they can
    // never be high together, and both drop as soon as reset asserts.
    assign bus.busy_o      = (state_q == RUN);
    assign bus.finish_o    = (state_q == DONE);
    assign bus.div_zero_o  = div_zero_q;
    assign bus.quotient_o  = res_quo_q;
    assign bus.remainder_o = res_rem_q;

endmodule
